// File: rtl/ch_est.sv
// ch_est: pilot-based channel magnitude estimator.
// Correlates 2^LOG2_LEN accepted pilot samples against a +/-1 pilot sequence,
// averages the correlation and presents a saturated unsigned magnitude on a
// valid/ready output held until the downstream equalizer accepts it.
// Optional build macro CH_EST_SAT_FLAG_EN adds the est_sat clamp-indicator port.
module ch_est #(
  parameter int W        = 8,
  parameter int M        = 2,
  parameter int LOG2_LEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] rx_in,
  input  logic                rx_valid,
  input  logic                pilot_bit,
  output logic [M-1:0]        est_out,
  output logic                est_valid,
  input  logic                est_ready,
  output logic                busy
`ifdef CH_EST_SAT_FLAG_EN
  ,
  output logic                est_sat
`endif
);

  // One guard bit above the worst-case sum so the correlation can never wrap.
  localparam int AW = W + LOG2_LEN + 1;
  localparam logic [AW-1:0] EST_MAX = AW'((2 ** M) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state_reg, state_next;
  logic signed [AW-1:0]  acc_reg;
  logic [LOG2_LEN-1:0]   cnt_reg;
  logic [M-1:0]          est_reg;

  logic signed [AW-1:0]  rx_ext;
  logic signed [AW-1:0]  acc_sum;
  logic [AW-1:0]         mag;
  logic [AW-1:0]         mag_shr;
  logic                  clamp_hit;
  logic [M-1:0]          est_clamped;
  logic                  take_sample;
  logic                  last_sample;

  // Sign extension happens before negation, so -2^(W-1) negates exactly.
  assign rx_ext      = {{(AW - W){rx_in[W-1]}}, rx_in};
  assign take_sample = (state_reg == ACCUM) && rx_valid;
  assign last_sample = take_sample && (cnt_reg == '1);

  // Correlation step and the averaged, clamped magnitude of the updated sum.
  always_comb begin
    acc_sum = pilot_bit ? (acc_reg + rx_ext) : (acc_reg - rx_ext);
    mag     = acc_sum[AW-1] ? unsigned'(-acc_sum) : unsigned'(acc_sum);
    mag_shr = mag >> LOG2_LEN;
    clamp_hit   = (mag_shr > EST_MAX);
    est_clamped = clamp_hit ? {M{1'b1}} : mag_shr[M-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode: start only from IDLE, leave DONE on the handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)       state_next = ACCUM;
      ACCUM:   if (last_sample) state_next = DONE;
      DONE:    if (est_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Accumulator, sample counter and captured estimate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      est_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (take_sample) begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + LOG2_LEN'(1);  // wraps to 0 on the final sample
      end
      if (last_sample) est_reg <= est_clamped;
    end
  end

`ifdef CH_EST_SAT_FLAG_EN
  logic sat_reg;

  // Clamp indicator captured together with the estimate.
  always_ff @(posedge clk) begin
    if (!rst_n)           sat_reg <= 1'b0;
    else if (last_sample) sat_reg <= clamp_hit;
  end

  assign est_sat = sat_reg;
`endif

  // Outputs decoded from the registered state.
  always_comb begin
    est_out   = est_reg;
    est_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_ch_est.sv
// tb_ch_est: table-driven self-checking bench for ch_est with a scoreboard
// queue of expected estimates; hand-written sequences cover DONE hold and
// reset abort.
module tb_ch_est;

  localparam int W = 8;
  localparam int M = 2;
  localparam int LOG2_LEN = 3;
  localparam int LEN = 1 << LOG2_LEN;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] rx_in = '0;
  logic                rx_valid = 1'b0;
  logic                pilot_bit = 1'b0;
  logic [M-1:0]        est_out;
  logic                est_valid;
  logic                est_ready = 1'b0;
  logic                busy;
`ifdef CH_EST_SAT_FLAG_EN
  logic                est_sat;
`endif

  ch_est #(.W(W), .M(M), .LOG2_LEN(LOG2_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_in(rx_in),
    .rx_valid(rx_valid), .pilot_bit(pilot_bit), .est_out(est_out),
    .est_valid(est_valid), .est_ready(est_ready), .busy(busy)
`ifdef CH_EST_SAT_FLAG_EN
    , .est_sat(est_sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] rx;
    int                  pol;   // 0: pilot -1, 1: pilot +1, 2: alternate starting +1
    int                  gap;   // max idle cycles between samples (0 = back-to-back)
    int                  hold;  // cycles est_ready stays low in DONE
    logic [M-1:0]        e_est;
    logic                e_sat;
  } vec_t;

  typedef struct {
    logic [M-1:0] est;
    logic         sat;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full burst: start, LEN samples, pop/compare, optional DONE hold, handshake.
  task automatic run_burst(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   waited;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < LEN; i++) begin
      if (v.gap > 0 && i > 0) begin
        int g;
        g = $urandom_range(1, v.gap);
        for (int k = 0; k < g; k++) begin
          rx_valid = 1'b0;
          rx_in    = 8'sd127;
          pilot_bit = 1'b1;
          step();
          chk("no_early_valid_gap", est_valid, 0);
        end
      end
      rx_valid  = 1'b1;
      rx_in     = v.rx;
      pilot_bit = (v.pol == 2) ? ((i % 2) == 0) : (v.pol == 1);
      if (i == LEN - 1) begin
        e.est = v.e_est;
        e.sat = v.e_sat;
        sbq.push_back(e);
      end
      chk("no_early_valid", est_valid, 0);
      step();
    end
    rx_valid = 1'b0;
    chk("latency_valid", est_valid, 1);
    waited = 0;
    while (!est_valid && waited < 4) begin
      step();
      waited++;
    end
    if (!est_valid) begin
      chk("valid_timeout", 0, 1);
      void'(sbq.pop_front());
    end else begin
      got = sbq.pop_front();
      chk("est_out", est_out, got.est);
`ifdef CH_EST_SAT_FLAG_EN
      chk("est_sat", est_sat, got.sat);
`endif
      $display("burst %0d rx=%0d pol=%0d est=%0d want=%0d", idx, v.rx, v.pol, est_out, got.est);
      for (int h = 0; h < v.hold; h++) begin
        start    = h[0];
        rx_valid = 1'b1;
        rx_in    = 8'sd50;
        step();
        chk("hold_valid", est_valid, 1);
        chk("hold_est", est_out, got.est);
        chk("hold_busy", busy, 1);
      end
      rx_valid  = 1'b0;
      est_ready = 1'b1;
      start     = 1'b1;   // same-cycle start must be ignored
      step();
      est_ready = 1'b0;
      start     = 1'b0;
      chk("handshake_valid_low", est_valid, 0);
      chk("handshake_busy_low", busy, 0);
      chk("est_kept", est_out, got.est);
      step();
      chk("no_restart", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rx: 8'sd2,    pol: 1, gap: 0, hold: 0, e_est: 2'd2, e_sat: 1'b0};
    vecs[1] = '{rx: -8'sd3,   pol: 0, gap: 0, hold: 0, e_est: 2'd3, e_sat: 1'b0};
    vecs[2] = '{rx: 8'sd1,    pol: 2, gap: 0, hold: 0, e_est: 2'd0, e_sat: 1'b0};
    vecs[3] = '{rx: 8'sd100,  pol: 1, gap: 0, hold: 0, e_est: 2'd3, e_sat: 1'b1};
    vecs[4] = '{rx: -8'sd128, pol: 0, gap: 0, hold: 0, e_est: 2'd3, e_sat: 1'b1};
    vecs[5] = '{rx: 8'sd2,    pol: 1, gap: 3, hold: 0, e_est: 2'd2, e_sat: 1'b0};
    vecs[6] = '{rx: 8'sd3,    pol: 1, gap: 0, hold: 5, e_est: 2'd3, e_sat: 1'b0};
    vecs[7] = '{rx: -8'sd2,   pol: 1, gap: 1, hold: 0, e_est: 2'd2, e_sat: 1'b0};
    vecs[8] = '{rx: 8'sd4,    pol: 1, gap: 0, hold: 2, e_est: 2'd3, e_sat: 1'b1};
    vecs[9] = '{rx: -8'sd1,   pol: 1, gap: 0, hold: 0, e_est: 2'd1, e_sat: 1'b0};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_est_out", est_out, 0);
    chk("rst_est_valid", est_valid, 0);
    chk("rst_busy", busy, 0);
`ifdef CH_EST_SAT_FLAG_EN
    chk("rst_est_sat", est_sat, 0);
`endif

    for (int i = 0; i < 10; i++) run_burst(i, vecs[i]);

    // Reset abort after 4 samples; est_out was 1 from the last burst.
    chk("pre_abort_est", est_out, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid  = 1'b1;
      rx_in     = 8'sd90;
      pilot_bit = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_est_out", est_out, 0);
    chk("abort_est_valid", est_valid, 0);
    chk("abort_busy", busy, 0);
    $display("abort after 4 samples est=%0d valid=%0d busy=%0d", est_out, est_valid, busy);
    begin
      vec_t v;
      v = '{rx: 8'sd1, pol: 1, gap: 0, hold: 0, e_est: 2'd1, e_sat: 1'b0};
      run_burst(10, v);
    end

    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_est.md
Name: ch_est

Overview:
- Pilot-based channel estimator that sits directly upstream of the channel equalizer and supplies its channel-response input.
- Correlates received pilot samples against a known ±1 pilot sequence over 2^LOG2_LEN samples.
- Averages the result and emits a saturated unsigned magnitude estimate of width M.
- Uses a valid/ready handshake so the equalizer's channel input can be refreshed once per training burst.

Parameters:
W, 8, received sample width (signed two's complement)
M, 2, estimate width; must match the equalizer channel-input width
LOG2_LEN, 3, log2 of the pilot burst length (burst = 2^LOG2_LEN accepted samples)

Ports:
clk  input  1  clock; all logic rising-edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a new estimation burst (honoured only in IDLE)
rx_in  input  W  received pilot sample, signed
rx_valid  input  1  rx_in valid this cycle (counted only in ACCUM)
pilot_bit  input  1  known pilot symbol: 1 = +1, 0 = -1
est_out  output  M  channel magnitude estimate, unsigned
est_valid  output  1  est_out valid; held until accepted
est_ready  input  1  downstream accepts est_out
busy  output  1  high in ACCUM or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising clk edge.
- Reset state: state=IDLE, acc=0, cnt=0, est_out=0, est_valid=0, busy=0.
- Reset mid-burst or mid-DONE aborts immediately with no output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 -> clear acc and cnt, go to ACCUM next cycle.
  - busy=1 from that next cycle.
- ACCUM:
  - Each cycle with rx_valid=1: acc += sext(rx_in) if pilot_bit=1, else acc -= sext(rx_in); cnt += 1.
  - Cycles with rx_valid=0 leave acc and cnt unchanged. Gaps of any length are allowed.
- Accumulator:
  - Signed, W+LOG2_LEN+1 bits, so it never overflows.
  - Negating -2^(W-1) is exact because sign extension happens before negation.
- Final sample: the valid sample accepted while cnt = 2^LOG2_LEN-1.
  - Next cycle: state=DONE, est_valid=1.
  - est_out = min(|acc_final| >> LOG2_LEN, 2^M-1); the shift is a floor of the magnitude.
  - Latency: est_valid rises exactly 1 cycle after the final sample's clock edge.
- DONE:
  - est_out and est_valid are held stable while est_ready=0.
  - On the cycle with est_valid=1 and est_ready=1: transfer completes, next cycle state=IDLE, est_valid=0, busy=0.
  - est_out keeps its last value after the transfer (not cleared).
  - rx_valid and rx_in are ignored.
- start asserted in ACCUM or DONE is ignored; no restart and no queuing.
- start in the same cycle as the handshake completion is ignored. A new burst needs start in IDLE.
- cnt wraps to 0 on entry to DONE. No partial estimate is produced if a burst is aborted by reset.

Optional Feature:
Macro CH_EST_SAT_FLAG_EN.
- Defined:
  - Adds output port est_sat (1 bit).
  - est_sat is registered alongside est_out: 1 when |acc_final| >> LOG2_LEN > 2^M-1 (clamping occurred), else 0.
  - Held with est_out; reset value 0.
- Not defined: port absent. Clamping behaviour of est_out is identical.

Test Plan:
1. W=8, M=2, LOG2_LEN=3: start, then 8 back-to-back samples rx_in=2, pilot_bit=1 -> est_valid=1 one cycle after the 8th sample, est_out=2 (acc=16); est_ready=1 -> est_valid=0 next cycle, busy=0.
2. 8 samples rx_in=-3, pilot_bit=0 -> acc=+24, est_out=3. Alternate rx_in=1 with pilot_bit toggling 1/0 -> acc=0, est_out=0.
3. 8 samples rx_in=100, pilot_bit=1 -> est_out saturates to 3; with CH_EST_SAT_FLAG_EN, est_sat=1. Repeat with rx_in=-128, pilot_bit=0 -> acc=+1024, est_out=3, est_sat=1.
4. 8 samples rx_in=2, pilot_bit=1, with rx_valid=0 gaps of 1-3 cycles between them -> same result as test 1; est_valid rises 1 cycle after the 8th valid sample; no early est_valid.
5. Hold est_ready=0 for 5 cycles in DONE and pulse start and rx_valid -> est_out and est_valid stable, state stays DONE; est_ready=1 -> IDLE next cycle.
6. Assert rst_n=0 for one cycle after 4 of 8 samples -> next cycle est_out=0, est_valid=0, busy=0. A fresh start plus 8 samples of rx_in=1, pilot_bit=1 -> est_out=1, with no residue from the aborted burst.
